skid_buf: RTL and testbench

- Two-entry registered ready/valid pipeline slice: the consumer-facing counterpart to the plain enable-register stage.
- A register with enable only captures data. This block also drives data out to a downstream reader under backpressure, and breaks the combinational ready path with a skid register.
- Sits between queue datapath stages and at the queue dequeue port.
- Full throughput: one word per cycle.

---
 rtl/skid_buf.sv | 108 ++++++++++
 tb/tb_skid_buf.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/skid_buf.sv
// Two-entry registered ready/valid slice: main register drives the outputs, skid register absorbs one word under backpressure.
// Optional stall counter for dequeue backpressure profiling is enabled by defining SKID_BUF_STALL_CNT_EN.
module skid_buf #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
`ifdef SKID_BUF_STALL_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt
`endif
);

  // state | meaning
  // EMPTY | main_v=0, skid_v=0: nothing held
  // BUSY  | main_v=1, skid_v=0: one word on the outputs, skid free
  // FULL  | main_v=1, skid_v=1: main on the outputs, next word parked in skid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_main_d;
  logic [W-1:0]   r_skid_d;
  logic           w_load_main_in;
  logic           w_load_main_skid;
  logic           w_load_skid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in)
        r_main_d <= in_data;
      else if (w_load_main_skid)
        r_main_d <= r_skid_d;
      if (w_load_skid)
        r_skid_d <= in_data;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (in_valid) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = BUSY;
        end
      end
      BUSY: begin
        case ({in_valid, out_ready})
          2'b11: w_load_main_in = 1'b1;
          2'b10: begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end
          2'b01: w_state_nxt = EMPTY;
          default: w_state_nxt = BUSY;
        endcase
      end
      FULL: begin
        // in_valid is ignored here: in_ready is already low
        if (out_ready) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = ~r_state[0];
    out_valid = r_state[1];
    out_data  = r_main_d;
  end

`ifdef SKID_BUF_STALL_CNT_EN
  logic [CW-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (out_valid && !out_ready && (r_stall_cnt != {CW{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skid_buf.sv
// Directed bench for skid_buf: scoreboard queue of accepted words, checked in order as they leave.
// Stall-counter steps run only when SKID_BUF_STALL_CNT_EN is defined (instance uses CW=2).
module tb_skid_buf;
  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
`ifdef SKID_BUF_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_asrt = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];

  skid_buf #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef SKID_BUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; handshakes are sampled on the falling edge, returns 1 time unit after the rising edge.
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", {63'd0, out_valid}, 64'd0);
        else check("out_data", {32'd0, out_data}, {32'd0, sb.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic iv, input logic [W-1:0] d, input logic ordy, input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc(iv, d, ordy);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset and idle
    do_reset(1'b0, '0, 1'b0, 2);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_data",  {32'd0, out_data},  64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD, 1'b1);
      check("idle_out_valid", {63'd0, out_valid}, 64'd0);
      check("idle_in_ready",  {63'd0, in_ready},  64'd1);
      check("idle_out_data",  {32'd0, out_data},  64'd0);
    end

    // full-rate streaming
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, W'(i), 1'b1);
      check("stream_out_valid", {63'd0, out_valid}, 64'd1);
      check("stream_out_data",  {32'd0, out_data},  64'(i));
      check("stream_in_ready",  {63'd0, in_ready},  64'd1);
    end
    cyc(1'b0, '0, 1'b1);
    check("stream_drain_valid", {63'd0, out_valid}, 64'd0);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // backpressure into skid, then drain
    cyc(1'b1, 32'hA, 1'b0);
    check("bp_in_ready_busy", {63'd0, in_ready}, 64'd1);
    cyc(1'b1, 32'hB, 1'b0);
    check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    check("bp_hold_data",     {32'd0, out_data}, 64'hA);
    cyc(1'b0, '0, 1'b1);
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    check("bp_next_data",     {32'd0, out_data}, 64'hB);
    cyc(1'b0, '0, 1'b1);
    check("bp_empty", {63'd0, out_valid}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // FULL ignores incoming word until in_ready returns
    cyc(1'b1, 32'hA, 1'b0);
    cyc(1'b1, 32'hB, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 32'hC, 1'b0);
      check("full_hold_valid", {63'd0, out_valid}, 64'd1);
      check("full_hold_data",  {32'd0, out_data},  64'hA);
      check("full_in_ready",   {63'd0, in_ready},  64'd0);
    end
    cyc(1'b1, 32'hC, 1'b1);
    check("full_drain_b", {32'd0, out_data}, 64'hB);
    cyc(1'b1, 32'hC, 1'b1);
    check("full_c_late", {32'd0, out_data}, 64'hC);
    cyc(1'b0, '0, 1'b1);
    check("full_done_valid", {63'd0, out_valid}, 64'd0);
    check("full_sb_empty", 64'(sb.size()), 64'd0);

    // reset from FULL discards held words
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    check("pre_rst_full", {63'd0, in_ready}, 64'd0);
    do_reset(1'b1, 32'h33, 1'b1, 1);
    check("rstfull_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstfull_in_ready",  {63'd0, in_ready},  64'd1);
    check("rstfull_out_data",  {32'd0, out_data},  64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("rstfull_no_stale", {63'd0, out_valid}, 64'd0);
    end

`ifdef SKID_BUF_STALL_CNT_EN
    // stall counter saturates at 3 with CW=2
    do_reset(1'b0, '0, 1'b0, 1);
    check("stall_rst0", {62'd0, stall_cnt}, 64'd0);
    cyc(1'b1, 32'h55, 1'b0);
    check("stall_first_load", {62'd0, stall_cnt}, 64'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, '0, 1'b0);
      check("stall_cnt", {62'd0, stall_cnt}, (i < 3) ? 64'(i) : 64'd3);
    end
    do_reset(1'b0, '0, 1'b0, 1);
    check("stall_rst", {62'd0, stall_cnt}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
